// File: rtl/bht2_predictor.sv
// Branch history table of 2-bit saturating counters with registered lookup and perf counters.
// Optional macro BHT_BYPASS_EN: same-index read/write in one cycle returns the post-update value.

module bht2_entry (
  input  logic       clk,
  input  logic       clr,
  input  logic       we_i,
  input  logic [1:0] d_i,
  output logic [1:0] q_o
);
  logic [1:0] state_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)       state_q <= 2'b01;
    else if (we_i) state_q <= d_i;
  end

  assign q_o = state_q;
endmodule

module bht2_predictor #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic             rd_taken,
  output logic [1:0]       rd_state,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken,
  input  logic             wr_mispred,
  output logic [CNT_W-1:0] cnt_lookup,
  output logic [CNT_W-1:0] cnt_mispred
);
  localparam int N = 1 << IDX_W;

  logic [N-1:0][1:0] tbl;
  logic [1:0]        wr_cur, wr_nxt, rd_state_d;
  logic              rd_valid_q;
  logic [1:0]        rd_state_q;
  logic [CNT_W-1:0]  cnt_lookup_q, cnt_mispred_q;

  // Only one entry is written per cycle, so a single saturating step suffices.
  assign wr_cur = tbl[wr_idx];

  always_comb begin
    wr_nxt = wr_cur;
    if (wr_taken) begin
      if (wr_cur != 2'b11) wr_nxt = wr_cur + 2'b01;
    end else begin
      if (wr_cur != 2'b00) wr_nxt = wr_cur - 2'b01;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_ent
    bht2_entry u_ent (
      .clk  (clk),
      .clr  (clr),
      .we_i (wr_en && (wr_idx == IDX_W'(g))),
      .d_i  (wr_nxt),
      .q_o  (tbl[g])
    );
  end

`ifdef BHT_BYPASS_EN
  always_comb begin
    rd_state_d = tbl[rd_idx];
    if (wr_en && (wr_idx == rd_idx)) rd_state_d = wr_nxt;
  end
`else
  always_comb begin
    rd_state_d = tbl[rd_idx];
  end
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rd_valid_q <= 1'b0;
      rd_state_q <= 2'b00;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_state_q <= rd_state_d;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_lookup_q  <= '0;
      cnt_mispred_q <= '0;
    end else begin
      if (rd_en && !(&cnt_lookup_q))                 cnt_lookup_q  <= cnt_lookup_q + 1'b1;
      if (wr_en && wr_mispred && !(&cnt_mispred_q)) cnt_mispred_q <= cnt_mispred_q + 1'b1;
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_state    = rd_state_q;
  assign rd_taken    = rd_state_q[1];
  assign cnt_lookup  = cnt_lookup_q;
  assign cnt_mispred = cnt_mispred_q;
endmodule

// File: doc/bht2_predictor.md
# bht2_predictor

Branch history table of 2-bit saturating counters for the pipelined CPU. The IF stage reads it with a registered lookup; the EX stage writes it when a branch resolves. It is the reader/writer counterpart to the 2-bit clearable state flops used elsewhere in the pipeline. It also keeps lookup and misprediction counts for the performance registers.

## Interface
Parameters:
- IDX_W, 4, index width; table holds 2**IDX_W entries.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- clr  input  1  reset, asynchronous, active-high.
- rd_en  input  1  lookup request from IF.
- rd_idx  input  IDX_W  lookup index (pc[IDX_W+1:2] supplied by IF).
- rd_valid  output  1  prediction valid, one cycle after rd_en.
- rd_taken  output  1  predicted direction (counter MSB).
- rd_state  output  2  counter value that produced rd_taken.
- wr_en  input  1  branch resolved in EX.
- wr_idx  input  IDX_W  index of the resolved branch.
- wr_taken  input  1  actual outcome.
- wr_mispred  input  1  EX flags this branch as mispredicted; counted only.
- cnt_lookup  output  CNT_W  number of accepted lookups.
- cnt_mispred  output  CNT_W  number of wr_en cycles with wr_mispred=1.

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction is taken when the counter is 1x.
- On clr, every entry resets to 01. rd_valid, rd_taken, rd_state, cnt_lookup and cnt_mispred reset to 0.
- Update on wr_en:
  - wr_taken=1: counter +1, saturating at 11.
  - wr_taken=0: counter -1, saturating at 00.
  - Only entry wr_idx changes.
- Lookup on rd_en: the next edge registers rd_state = entry[rd_idx], rd_taken = rd_state[1], rd_valid = 1.
- rd_en=0: rd_valid goes to 0 on the next edge. rd_taken and rd_state hold their last values.
- cnt_lookup increments on each rd_en cycle and saturates at all-ones.
- cnt_mispred increments on each wr_en & wr_mispred cycle and saturates at all-ones.
- Counters are not cleared except by clr.
- Same-cycle read and write to different indices: the two operations are independent.
- Same-cycle read and write to the same index: behaviour is set by the Configuration macro.
- No state machine beyond the per-entry counters. The block never stalls; both ports accept every cycle.

## Timing
- Lookup latency is 1 cycle: rd_en at edge N gives rd_valid/rd_taken at edge N+1.
- Write latency is 1 cycle: the entry holds its new value after the edge where wr_en is sampled. A read at N+1 sees it.
- clr asserted mid-operation clears all state immediately, without waiting for a clock edge.
  - While clr is high, rd_valid=0 and all updates are ignored.
  - The first edge after clr deasserts accepts rd_en/wr_en normally.
- No combinational path from inputs to outputs.

## Configuration
- BHT_BYPASS_EN defined: same-cycle rd_en/wr_en to the same index bypasses the table. rd_state returns the post-update counter value.
- BHT_BYPASS_EN undefined: the same case returns the pre-update value. The table is still updated at that edge.
- The macro affects only this collision case. All other behaviour is identical with or without it.

## Test plan
- Reset state: assert clr, then read all 16 indices → each rd_state=01, rd_taken=0, rd_valid=1 one cycle after each rd_en; counters report 16 lookups.
- Saturation up: three wr_en to idx 5 with wr_taken=1 → reads give 10, 11, 11. Two further taken writes keep it at 11. Three not-taken writes then read 10, 01, 00. A fourth not-taken write keeps 00.
- Collision: idx 3 = 01, same cycle rd_en/wr_en idx 3 with wr_taken=1 → rd_state=10 with BHT_BYPASS_EN, 01 without. A following read returns 10 in both builds.
- Independence: write idx 2 taken while reading idx 9 in the same cycle → idx 9 reads 01, and idx 2 reads 10 on the next lookup.
- Counters: 5 wr_en with wr_mispred=1 plus 2 with wr_mispred=0 → cnt_mispred=5. With CNT_W=4, 20 lookups → cnt_lookup=15 (saturated).
- Reset mid-run: raise clr asynchronously while rd_en=1 and idx 5=11 → rd_valid drops at once with no clock edge. After release, idx 5 reads 01.
